// File: rtl/iro_pkg.sv
// Shared types and constants for the ring-oscillator seed loader.
package iro_pkg;

    localparam int N_STAGES_DEFAULT = 25;
    localparam int PHASE_W          = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        SETTLE   = 3'd3,
        RUN      = 3'd4,
        HOLD     = 3'd5,
        DONE     = 3'd6
    } iro_state_e;

    // A programmed hold of zero still freezes the ring for one cycle.
    function automatic logic [7:0] hold_eff(input logic [7:0] h);
        return (h == 8'd0) ? 8'd1 : h;
    endfunction

endpackage

// File: rtl/iro_phase_sync.sv
// Multi-flop synchroniser for asynchronous phase taps; every stage resets to 0.
module iro_phase_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/iro_seed_loader.sv
// Seed shifter and measurement sequencer for one ring-oscillator cycle.
// Optional phase[0] edge counter enabled by defining IRO_LOADER_EDGE_COUNT_EN.
module iro_seed_loader
    import iro_pkg::*;
#(
    parameter int N_STAGES      = N_STAGES_DEFAULT,
    parameter int CLK_DIV       = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_STAGES-1:0] seed_in,
    input  logic [3:0]          n_stages_in,
    input  logic [15:0]         run_cycles,
    input  logic [7:0]          hold_cycles,
    input  logic [PHASE_W-1:0]  phases,
    output logic                bclk,
    output logic                bdat,
    output logic                enable,
    output logic                hold,
    output logic [3:0]          n_stages,
    output logic                busy,
    output logic                done,
    output logic [PHASE_W-1:0]  result,
`ifdef IRO_LOADER_EDGE_COUNT_EN
    output logic [15:0]         edge_count,
`endif
    output iro_state_e          dbg_state
);

    localparam int BIT_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // A zero settle parameter still spends one cycle in SETTLE.
    localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    iro_state_e          state_q, state_d;
    logic [N_STAGES-1:0] seed_q, seed_d;
    logic [3:0]          n_stages_q, n_stages_d;
    logic [15:0]         run_q, run_d;
    logic [7:0]          hold_cyc_q, hold_cyc_d;
    logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                bclk_q, bclk_d;
    logic                bdat_q, bdat_d;
    logic                enable_q, enable_d;
    logic                hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PHASE_W-1:0]  result_q, result_d;
    logic [PHASE_W-1:0]  sync_out;
    logic [15:0]         hold_last;

    iro_phase_sync #(
        .WIDTH (PHASE_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (phases),
        .q     (sync_out)
    );

    // Hold spans the programmed hold plus the synchroniser depth so the
    // captured value reflects the frozen ring.
    assign hold_last = 16'(hold_eff(hold_cyc_q)) + 16'(SYNC_STAGES - 1);

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        n_stages_d = n_stages_q;
        run_d      = run_q;
        hold_cyc_d = hold_cyc_q;
        bit_idx_d  = bit_idx_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bclk_d     = bclk_q;
        bdat_d     = bdat_q;
        enable_d   = enable_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d     = seed_in;
                    n_stages_d = n_stages_in;
                    run_d      = run_cycles;
                    hold_cyc_d = hold_cycles;
                    bit_idx_d  = BIT_W'(N_STAGES - 1);
                    div_d      = DIV_LAST;
                    bclk_d     = 1'b0;
                    bdat_d     = seed_in[N_STAGES-1];
                    busy_d     = 1'b1;
                    state_d    = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_q == '0) begin
                    bclk_d  = 1'b1;
                    div_d   = DIV_LAST;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_q == '0) begin
                    bclk_d = 1'b0;
                    div_d  = DIV_LAST;
                    if (bit_idx_q == '0) begin
                        bdat_d  = 1'b0;
                        cnt_d   = SETTLE_LAST;
                        state_d = SETTLE;
                    end else begin
                        bit_idx_d = bit_idx_q - BIT_W'(1);
                        bdat_d    = seed_q[bit_idx_d];
                        state_d   = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == 16'd0) begin
                    enable_d = 1'b1;
                    if (run_q == 16'd0) begin
                        hold_d  = 1'b1;
                        cnt_d   = hold_last;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = run_q - 16'd1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RUN: begin
                if (cnt_q == 16'd0) begin
                    hold_d  = 1'b1;
                    cnt_d   = hold_last;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 16'd0) begin
                    enable_d = 1'b0;
                    hold_d   = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = sync_out;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            n_stages_q <= '0;
            run_q      <= '0;
            hold_cyc_q <= '0;
            bit_idx_q  <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            bclk_q     <= 1'b0;
            bdat_q     <= 1'b0;
            enable_q   <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            n_stages_q <= n_stages_d;
            run_q      <= run_d;
            hold_cyc_q <= hold_cyc_d;
            bit_idx_q  <= bit_idx_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bclk_q     <= bclk_d;
            bdat_q     <= bdat_d;
            enable_q   <= enable_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

`ifdef IRO_LOADER_EDGE_COUNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;
    logic        ph0_prev_q;

    // Only edges seen while the ring runs free are counted.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (state_q == IDLE && start) begin
            edge_cnt_d = 16'd0;
        end else if (enable_q && !hold_q && sync_out[0] && !ph0_prev_q &&
                     edge_cnt_q != 16'hFFFF) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            ph0_prev_q <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            ph0_prev_q <= sync_out[0];
        end
    end

    assign edge_count = edge_cnt_q;
`endif

    assign bclk      = bclk_q;
    assign bdat      = bdat_q;
    assign enable    = enable_q;
    assign hold      = hold_q;
    assign n_stages  = n_stages_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_iro_seed_loader.sv
// Directed bench for iro_seed_loader: instance a uses CLK_DIV=4, instance b CLK_DIV=1.
module tb_iro_seed_loader;
    import iro_pkg::*;

    localparam int N = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          a_start, a_bclk, a_bdat, a_enable, a_hold_o, a_busy, a_done;
    logic [N-1:0]  a_seed;
    logic [3:0]    a_nsi, a_nst;
    logic [15:0]   a_run, a_phases, a_result;
    logic [7:0]    a_hold;
    iro_state_e    a_state;

    logic          b_start, b_bclk, b_bdat, b_enable, b_hold_o, b_busy, b_done;
    logic [N-1:0]  b_seed;
    logic [3:0]    b_nsi, b_nst;
    logic [15:0]   b_run, b_phases, b_result;
    logic [7:0]    b_hold;
    iro_state_e    b_state;

`ifdef IRO_LOADER_EDGE_COUNT_EN
    logic [15:0]   a_edge, b_edge;
`endif

    int checks = 0;
    int errors = 0;

    iro_seed_loader #(.N_STAGES(N), .CLK_DIV(4), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .seed_in(a_seed), .n_stages_in(a_nsi),
        .run_cycles(a_run), .hold_cycles(a_hold), .phases(a_phases), .bclk(a_bclk),
        .bdat(a_bdat), .enable(a_enable), .hold(a_hold_o), .n_stages(a_nst), .busy(a_busy),
        .done(a_done), .result(a_result),
`ifdef IRO_LOADER_EDGE_COUNT_EN
        .edge_count(a_edge),
`endif
        .dbg_state(a_state)
    );

    iro_seed_loader #(.N_STAGES(N), .CLK_DIV(1), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .seed_in(b_seed), .n_stages_in(b_nsi),
        .run_cycles(b_run), .hold_cycles(b_hold), .phases(b_phases), .bclk(b_bclk),
        .bdat(b_bdat), .enable(b_enable), .hold(b_hold_o), .n_stages(b_nst), .busy(b_busy),
        .done(b_done), .result(b_result),
`ifdef IRO_LOADER_EDGE_COUNT_EN
        .edge_count(b_edge),
`endif
        .dbg_state(b_state)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_seed = '0; a_nsi = '0; a_run = '0; a_hold = '0; a_phases = '0;
        b_start = 0; b_seed = '0; b_nsi = '0; b_run = '0; b_hold = '0; b_phases = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_bclk, a_bdat, a_enable, a_hold_o, a_nst, a_busy, a_done, a_result} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs_a got %h exp 0",
                     {a_bclk, a_bdat, a_enable, a_hold_o, a_nst, a_busy, a_done, a_result});
        end
        checks++;
        if ({b_bclk, b_bdat, b_enable, b_hold_o, b_nst, b_busy, b_done, b_result} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs_b got %h exp 0",
                     {b_bclk, b_bdat, b_enable, b_hold_o, b_nst, b_busy, b_done, b_result});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_state !== IDLE) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b state=%0d exp busy=0 state=0", a_busy, a_state);
        end
    endtask

    task automatic test_seed_load();
        logic [N-1:0] sr = '0;
        logic [N-1:0] settle_sr = '0;
        logic settle_seen = 0, first = 0, prev_bclk, prev_bdat;
        logic period_ok = 1, stable_ok = 1;
        int rises = 0, last = 0, cyc = 0;
        a_seed = 25'h1555555; a_nsi = 4'd9; a_run = 16'd0; a_hold = 8'd1; a_phases = 16'h0000;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        checks++;
        if (a_nst !== 4'd9 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL seed_start got n_stages=%0d busy=%b exp n_stages=9 busy=1", a_nst, a_busy);
        end
        prev_bclk = a_bclk; prev_bdat = a_bdat;
        while (!a_done && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (a_bclk && !prev_bclk) begin
                sr = {sr[N-2:0], a_bdat};
                if (rises == 0) first = a_bdat;
                else if (cyc - last != 8) period_ok = 0;
                last = cyc; rises++;
            end
            if (a_bdat !== prev_bdat && a_bclk) stable_ok = 0;
            if (a_state == SETTLE && !settle_seen) begin settle_seen = 1; settle_sr = sr; end
            prev_bclk = a_bclk; prev_bdat = a_bdat;
        end
        checks++;
        if (!a_done) begin errors++; $display("FAIL seed_timeout got no done exp done within 1000"); end
        checks++;
        if (rises != 25) begin errors++; $display("FAIL seed_rises got %0d exp 25", rises); end
        checks++;
        if (first !== 1'b1) begin errors++; $display("FAIL seed_first_bit got %b exp 1", first); end
        checks++;
        if (!period_ok) begin errors++; $display("FAIL seed_bit_period got irregular exp 8"); end
        checks++;
        if (!stable_ok) begin errors++; $display("FAIL seed_bdat_stable got change with bclk=1 exp none"); end
        checks++;
        if (settle_sr !== 25'h1555555) begin
            errors++; $display("FAIL seed_model got %h exp 1555555", settle_sr);
        end
        @(negedge clk);
    endtask

    task automatic test_capture();
        int en = 0, hc = 0, enh = 0, dn = 0, cyc = 0;
        logic [15:0] res = '0;
        logic busy_at_done = 1'b1;
        a_phases = 16'hA5A5; a_seed = 25'h0000001; a_run = 16'd0; a_hold = 8'd1;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (dn == 0 && cyc < 1000) begin
            if (a_enable) en++;
            if (a_hold_o) hc++;
            if (a_enable && !a_hold_o) enh++;
            if (a_done) begin dn++; res = a_result; busy_at_done = a_busy; end
            if (dn == 0) begin @(negedge clk); cyc++; end
        end
        repeat (10) begin
            @(negedge clk);
            if (a_done) dn++;
        end
        checks++;
        if (en != 3) begin errors++; $display("FAIL cap_enable_cycles got %0d exp 3", en); end
        checks++;
        if (hc != 3) begin errors++; $display("FAIL cap_hold_cycles got %0d exp 3", hc); end
        checks++;
        if (enh != 0) begin errors++; $display("FAIL cap_run_cycles got %0d exp 0", enh); end
        checks++;
        if (res !== 16'hA5A5) begin errors++; $display("FAIL cap_result got %h exp a5a5", res); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL cap_busy_at_done got %b exp 0", busy_at_done); end
        checks++;
        if (dn != 1) begin errors++; $display("FAIL cap_done_pulses got %0d exp 1", dn); end
        checks++;
        if (a_result !== 16'hA5A5) begin errors++; $display("FAIL cap_result_held got %h exp a5a5", a_result); end
    endtask

    task automatic test_midrun_reset();
        int cyc = 0;
        a_seed = 25'h1FFFFFF;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        while (!(a_bclk && a_bdat) && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if (!(a_bclk && a_bdat)) begin errors++; $display("FAIL mid_reset_setup got bclk=%b exp 1", a_bclk); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_bclk, a_bdat, a_enable, a_hold_o, a_nst, a_busy, a_done, a_result} !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h exp 0",
                     {a_bclk, a_bdat, a_enable, a_hold_o, a_nst, a_busy, a_done, a_result});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_state !== IDLE || a_result !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_release got busy=%b state=%0d result=%h exp 0 0 0", a_busy, a_state, a_result);
        end
    endtask

    task automatic test_busy_ignore();
        logic [N-1:0] sr = '0;
        logic prev_bclk, pulsed = 0, busy_extra = 0;
        int rises = 0, dn = 0, cyc = 0;
        a_seed = 25'h1234567; a_run = 16'd3; a_hold = 8'd2;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        prev_bclk = a_bclk;
        while (dn == 0 && cyc < 1000) begin
            @(negedge clk); cyc++;
            a_start = 1'b0;
            if (a_bclk && !prev_bclk) begin sr = {sr[N-2:0], a_bdat}; rises++; end
            if (a_done) dn++;
            if (rises == 12 && !pulsed) begin a_start = 1'b1; a_seed = 25'h0EDCBA9; pulsed = 1; end
            prev_bclk = a_bclk;
        end
        repeat (40) begin
            @(negedge clk);
            if (a_bclk && !prev_bclk) begin sr = {sr[N-2:0], a_bdat}; rises++; end
            if (a_done) dn++;
            if (a_busy) busy_extra = 1;
            prev_bclk = a_bclk;
        end
        checks++;
        if (sr !== 25'h1234567 || rises != 25) begin
            errors++; $display("FAIL busy_ignore_seed got %h rises=%0d exp 1234567 rises=25", sr, rises);
        end
        checks++;
        if (dn != 1 || busy_extra) begin
            errors++; $display("FAIL busy_ignore_done got done=%0d busy_after=%b exp 1 0", dn, busy_extra);
        end
    endtask

    task automatic test_timing();
        int en = 0, hc = 0, k = 1, done_k = 0;
        b_seed = 25'h0AAAAAA; b_run = 16'd10; b_hold = 8'd5; b_phases = 16'h3C5A;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (k < 500) begin
            if (b_enable) en++;
            if (b_hold_o) hc++;
            if (b_done) begin done_k = k; break; end
            @(negedge clk); k++;
        end
        checks++;
        if (en != 17) begin errors++; $display("FAIL timing_enable got %0d exp 17", en); end
        checks++;
        if (hc != 7) begin errors++; $display("FAIL timing_hold got %0d exp 7", hc); end
        checks++;
        if (done_k + 1 != 1 + 50 + 4 + 10 + 7 + 1) begin
            errors++; $display("FAIL timing_start_to_done got %0d exp 73", done_k + 1);
        end
        checks++;
        if (b_result !== 16'h3C5A) begin errors++; $display("FAIL timing_result got %h exp 3c5a", b_result); end
        @(negedge clk);
    endtask

`ifdef IRO_LOADER_EDGE_COUNT_EN
    task automatic test_edge_count();
        int r = 0, cyc = 0;
        b_phases = 16'h0; b_run = 16'd64; b_hold = 8'd1;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (!b_done && cyc < 1000) begin
            if (b_enable && !b_hold_o) begin b_phases[0] = ((r % 16) < 8); r++; end
            else b_phases[0] = 1'b0;
            @(negedge clk); cyc++;
        end
        checks++;
        if (b_edge !== 16'd4) begin errors++; $display("FAIL edge_count_run64 got %0d exp 4", b_edge); end
        repeat (5) @(negedge clk);
        checks++;
        if (b_edge !== 16'd4) begin errors++; $display("FAIL edge_count_stable got %0d exp 4", b_edge); end
        b_run = 16'd0; cyc = 0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (!b_done && cyc < 1000) begin
            b_phases[0] = ((cyc % 16) < 8);
            @(negedge clk); cyc++;
        end
        checks++;
        if (b_edge !== 16'd0) begin errors++; $display("FAIL edge_count_run0 got %0d exp 0", b_edge); end
        b_phases = 16'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_seed_load();
        test_capture();
        test_midrun_reset();
        test_busy_ignore();
        test_timing();
`ifdef IRO_LOADER_EDGE_COUNT_EN
        test_edge_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
